// File: rtl/dm_cache_ctrl.sv
// rtl/dm_cache_ctrl.sv - direct-mapped cache sequencer (write-through, read-allocate)
// Optional DM_CACHE_STATS_EN adds saturating hit_cnt/miss_cnt outputs.
module dm_cache_ctrl #(
    parameter int INDEX_LEN   = 8,
    parameter int TAG_LEN     = 8,
    parameter int NUM_CACHE_L = 2 ** INDEX_LEN,
    parameter int DATA_W      = 32
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         cpu_req,
    input  logic                         cpu_we,
    input  logic [TAG_LEN+INDEX_LEN-1:0] cpu_addr,
    input  logic [DATA_W-1:0]            cpu_wdata,
    output logic                         cpu_ready,
    output logic                         cpu_rvalid,
    output logic [DATA_W-1:0]            cpu_rdata,
    output logic                         cpu_wdone,
    output logic                         tag_write,
    output logic [INDEX_LEN-1:0]         tag_index,
    output logic [TAG_LEN-1:0]           tag_wdata,
    input  logic [TAG_LEN-1:0]           tag_rdata,
    output logic                         dat_write,
    output logic [INDEX_LEN-1:0]         dat_index,
    output logic [DATA_W-1:0]            dat_wdata,
    input  logic [DATA_W-1:0]            dat_rdata,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [TAG_LEN+INDEX_LEN-1:0] mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic                         mem_ack,
    input  logic [DATA_W-1:0]            mem_rdata
`ifdef DM_CACHE_STATS_EN
    ,
    output logic [31:0]                  hit_cnt,
    output logic [31:0]                  miss_cnt
`endif
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOOKUP  = 3'd1;
    localparam logic [2:0] RD_MISS = 3'd2;
    localparam logic [2:0] FILL    = 3'd3;
    localparam logic [2:0] WR_THRU = 3'd4;

    logic [2:0]                   state;
    logic                         run;
    logic [TAG_LEN+INDEX_LEN-1:0] lat_addr;
    logic                         lat_we;
    logic [DATA_W-1:0]            lat_wdata;
    logic [DATA_W-1:0]            fill_data;
    logic [NUM_CACHE_L-1:0]       valid;
    logic [INDEX_LEN-1:0]         lat_idx;
    logic [TAG_LEN-1:0]           lat_tag;
    logic                         hit;

    assign lat_idx = lat_addr[INDEX_LEN-1:0];
    assign lat_tag = lat_addr[TAG_LEN+INDEX_LEN-1:INDEX_LEN];
    assign hit     = valid[lat_idx] && (tag_rdata == lat_tag);

    // run keeps every output at 0 through the first edge after reset release
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            run       <= 1'b0;
            valid     <= '0;
            lat_addr  <= '0;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
            fill_data <= '0;
        end else begin
            run <= 1'b1;
            case (state)
                IDLE: begin
                    if (cpu_req && run) begin
                        lat_addr  <= cpu_addr;
                        lat_we    <= cpu_we;
                        lat_wdata <= cpu_wdata;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (lat_we)
                        state <= WR_THRU;
                    else if (hit)
                        state <= IDLE;
                    else
                        state <= RD_MISS;
                end
                RD_MISS: begin
                    if (mem_ack) begin
                        fill_data <= mem_rdata;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    valid[lat_idx] <= 1'b1;
                    state          <= IDLE;
                end
                WR_THRU: begin
                    if (mem_ack)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        cpu_ready  = 1'b0;
        cpu_rvalid = 1'b0;
        cpu_rdata  = '0;
        cpu_wdone  = 1'b0;
        tag_write  = 1'b0;
        tag_index  = lat_idx;
        tag_wdata  = '0;
        dat_write  = 1'b0;
        dat_index  = lat_idx;
        dat_wdata  = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                // arrays read the incoming index so LOOKUP sees tag/data next cycle
                cpu_ready = run;
                tag_index = run ? cpu_addr[INDEX_LEN-1:0] : '0;
                dat_index = run ? cpu_addr[INDEX_LEN-1:0] : '0;
            end
            LOOKUP: begin
                if (hit && !lat_we) begin
                    cpu_rvalid = 1'b1;
                    cpu_rdata  = dat_rdata;
                end
                if (hit && lat_we) begin
                    dat_write = 1'b1;
                    dat_wdata = lat_wdata;
                end
            end
            RD_MISS: begin
                mem_req  = 1'b1;
                mem_addr = lat_addr;
            end
            FILL: begin
                tag_write  = 1'b1;
                tag_wdata  = lat_tag;
                dat_write  = 1'b1;
                dat_wdata  = fill_data;
                cpu_rvalid = 1'b1;
                cpu_rdata  = fill_data;
            end
            WR_THRU: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = lat_addr;
                mem_wdata = lat_wdata;
                cpu_wdone = mem_ack;
            end
            default: ;
        endcase
    end

`ifdef DM_CACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == LOOKUP) begin
            if (hit) begin
                if (hit_cnt != 32'hFFFF_FFFF)
                    hit_cnt <= hit_cnt + 32'd1;
            end else if (miss_cnt != 32'hFFFF_FFFF) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb/tb_dm_cache_ctrl.sv - self-checking bench for dm_cache_ctrl
module tb_dm_cache_ctrl;
    localparam int IL = 8;
    localparam int TL = 8;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ready, cpu_rvalid, cpu_wdone;
    logic [31:0] cpu_rdata;
    logic        tag_write, dat_write;
    logic [7:0]  tag_index, dat_index, tag_wdata, tag_rdata;
    logic [31:0] dat_wdata, dat_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
`ifdef DM_CACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    always #5 clk = ~clk;

    dm_cache_ctrl #(.INDEX_LEN(IL), .TAG_LEN(TL), .NUM_CACHE_L(256), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_wdone(cpu_wdone),
        .tag_write(tag_write), .tag_index(tag_index), .tag_wdata(tag_wdata), .tag_rdata(tag_rdata),
        .dat_write(dat_write), .dat_index(dat_index), .dat_wdata(dat_wdata), .dat_rdata(dat_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef DM_CACHE_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    // registered-read tag/data arrays
    logic [7:0]  tag_mem [256];
    logic [31:0] dat_mem [256];
    always @(posedge clk) begin
        if (tag_write) tag_mem[tag_index] <= tag_wdata;
        else           tag_rdata <= tag_mem[tag_index];
        if (dat_write) dat_mem[dat_index] <= dat_wdata;
        else           dat_rdata <= dat_mem[dat_index];
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // reference model: cache contents and main memory
    bit          mvalid [256];
    logic [7:0]  mtag   [256];
    logic [31:0] mdata  [256];
    logic [31:0] mmem   [logic [15:0]];
    int          m_hits, m_misses;

    function automatic logic [31:0] mem_rd(input logic [15:0] a);
        return mmem.exists(a) ? mmem[a] : {~a, a};
    endfunction

    // expected schedule of the transaction in flight, cycle 1 = first cycle after accept
    bit          active, idle_chk;
    int          cyc;
    bit          e_we, e_hit, e_mem;
    logic [15:0] e_addr;
    logic [31:0] e_wdata, e_rdata;
    int          e_ack_cyc, e_resp_cyc;

    int          last_resp_cyc, mem_cycles;
    logic [31:0] last_rdata;
    logic [15:0] last_mem_addr;

    always @(negedge clk) begin
        if (active) begin
            bit fill, whit, req_exp;
            fill    = !e_we && !e_hit && cyc == e_resp_cyc;
            whit    = e_we && e_hit && cyc == 1;
            req_exp = e_mem && cyc >= 2 && cyc <= e_ack_cyc;
            chk("cpu_ready_busy", cpu_ready, 1'b0);
            chk("cpu_rvalid", cpu_rvalid, !e_we && cyc == e_resp_cyc);
            chk("cpu_wdone", cpu_wdone, e_we && cyc == e_resp_cyc);
            if (!e_we && cyc == e_resp_cyc) chk("cpu_rdata", cpu_rdata, e_rdata);
            chk("mem_req", mem_req, req_exp);
            if (mem_req) begin
                chk("mem_we", mem_we, e_we);
                chk("mem_addr", mem_addr, e_addr);
                if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
            end
            chk("tag_write", tag_write, fill);
            chk("dat_write", dat_write, fill || whit);
            if (tag_write) begin
                chk("tag_index", tag_index, e_addr[7:0]);
                chk("tag_wdata", tag_wdata, e_addr[15:8]);
            end
            if (dat_write) begin
                chk("dat_index", dat_index, e_addr[7:0]);
                chk("dat_wdata", dat_wdata, fill ? e_rdata : e_wdata);
            end
            if (cpu_rvalid || cpu_wdone) begin
                last_resp_cyc = cyc;
                last_rdata    = cpu_rdata;
            end
            if (mem_req) begin
                mem_cycles++;
                last_mem_addr = mem_addr;
            end
        end else if (idle_chk) begin
            chk("idle_ready", cpu_ready, 1'b1);
            chk("idle_rvalid", cpu_rvalid, 1'b0);
            chk("idle_wdone", cpu_wdone, 1'b0);
            chk("idle_mem_req", mem_req, 1'b0);
            chk("idle_strobes", {tag_write, dat_write}, 2'b00);
            chk("idle_tag_index", tag_index, cpu_addr[7:0]);
            chk("idle_dat_index", dat_index, cpu_addr[7:0]);
`ifdef DM_CACHE_STATS_EN
            chk("hit_cnt", hit_cnt, m_hits);
            chk("miss_cnt", miss_cnt, m_misses);
`endif
        end
    end

    // call just after a rising edge while idle; abort_at>0 returns early with the transaction live
    task automatic do_req(input bit we, input logic [15:0] addr, input logic [31:0] wdata,
                          input int d, input int abort_at);
        logic [7:0] idx, tag;
        idx        = addr[7:0];
        tag        = addr[15:8];
        e_we       = we;
        e_addr     = addr;
        e_wdata    = wdata;
        e_hit      = mvalid[idx] && mtag[idx] == tag;
        e_mem      = we || !e_hit;
        e_ack_cyc  = e_mem ? 2 + d : 0;
        e_rdata    = '0;
        if (!we) begin
            if (e_hit) begin
                e_resp_cyc = 1;
                e_rdata    = mdata[idx];
            end else begin
                e_resp_cyc  = 3 + d;
                e_rdata     = mem_rd(addr);
                mvalid[idx] = 1'b1;
                mtag[idx]   = tag;
                mdata[idx]  = e_rdata;
            end
        end else begin
            e_resp_cyc = 2 + d;
            mmem[addr] = wdata;
            if (e_hit) mdata[idx] = wdata;
        end
        last_resp_cyc = -1;
        mem_cycles    = 0;
        last_rdata    = '0;
        last_mem_addr = '0;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        @(posedge clk);
        #1;
        cpu_req   = 1'b0;
        cpu_we    = !we;
        cpu_addr  = ~addr;
        cpu_wdata = ~wdata;
        active    = 1'b1;
        cyc       = 1;
        while (cyc <= e_resp_cyc && !(abort_at > 0 && cyc == abort_at)) begin
            mem_ack   = e_mem && cyc == e_ack_cyc;
            mem_rdata = (mem_ack && !we) ? e_rdata : 32'h5A5A_0000 + cyc;
            @(posedge clk);
            #1;
            cyc++;
        end
        mem_ack = 1'b0;
        if (e_hit) m_hits++; else m_misses++;
        if (abort_at == 0) active = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            tag_mem[i] = '0;
            dat_mem[i] = 32'h0BAD_0000 + i;
            mvalid[i]  = 1'b0;
        end
        m_hits = 0; m_misses = 0;
        active = 1'b0; idle_chk = 1'b0; cyc = 0;
        resetn = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        cpu_addr = 16'h00FF; cpu_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", cpu_ready, 1'b0);
        chk("rst_rvalid", cpu_rvalid, 1'b0);
        chk("rst_wdone", cpu_wdone, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_strobes", {tag_write, dat_write}, 2'b00);
        chk("rst_tag_index", tag_index, 8'h00);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_rdata", cpu_rdata, 32'h0);
        @(posedge clk); #1; resetn = 1'b1;
        @(posedge clk); #1; idle_chk = 1'b1;

        mmem[16'h0010] = 32'hDEADBEEF;
        do_req(1'b0, 16'h0010, 32'h0, 1, 0);
        chk("lit_miss_rdata", last_rdata, 32'hDEADBEEF);
        chk("lit_miss_latency", last_resp_cyc, 4);
        chk("lit_miss_addr", last_mem_addr, 16'h0010);
        do_req(1'b0, 16'h0010, 32'h0, 0, 0);
        chk("lit_hit_rdata", last_rdata, 32'hDEADBEEF);
        chk("lit_hit_latency", last_resp_cyc, 1);
        chk("lit_hit_no_mem", mem_cycles, 0);
        do_req(1'b1, 16'h0010, 32'h12345678, 2, 0);
        chk("lit_wr_latency", last_resp_cyc, 4);
        chk("lit_wr_req_cycles", mem_cycles, 3);
        do_req(1'b0, 16'h0010, 32'h0, 0, 0);
        chk("lit_wr_hit_rdata", last_rdata, 32'h12345678);
        chk("lit_wr_hit_no_mem", mem_cycles, 0);
        do_req(1'b0, 16'h0510, 32'h0, 0, 0);
        do_req(1'b0, 16'h0010, 32'h0, 0, 0);
        chk("lit_conflict_rdata", last_rdata, 32'h12345678);
        chk("lit_conflict_latency", last_resp_cyc, 3);
        do_req(1'b1, 16'h2233, 32'hCAFEF00D, 0, 0);
        do_req(1'b0, 16'h2233, 32'h0, 1, 0);
        chk("lit_noalloc_rdata", last_rdata, 32'hCAFEF00D);
        chk("lit_noalloc_missed", mem_cycles, 2);
        do_req(1'b0, 16'h0733, 32'h0, 0, 0);
        do_req(1'b0, 16'hFFFF, 32'h0, 0, 0);
        do_req(1'b0, 16'hFFFF, 32'h0, 0, 0);
        do_req(1'b0, 16'h0000, 32'h0, 0, 0);
        do_req(1'b1, 16'h0000, 32'h0F0F_F0F0, 1, 0);
        do_req(1'b0, 16'h0000, 32'h0, 0, 0);

        do_req(1'b0, 16'h4410, 32'h0, 10, 3);
        resetn = 1'b0;
        @(posedge clk); #1;
        active = 1'b0; idle_chk = 1'b0; resetn = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("rst_mid_mem_req", mem_req, 1'b0);
        chk("rst_mid_rvalid", cpu_rvalid, 1'b0);
        chk("rst_mid_ready", cpu_ready, 1'b0);
        chk("rst_mid_strobes", {tag_write, dat_write}, 2'b00);
`ifdef DM_CACHE_STATS_EN
        chk("rst_hit_cnt", hit_cnt, 32'd0);
        chk("rst_miss_cnt", miss_cnt, 32'd0);
`endif
        @(posedge clk); #1; mem_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_rvalid", cpu_rvalid, 1'b0);
        chk("late_ack_ready", cpu_ready, 1'b1);
        chk("late_ack_mem_req", mem_req, 1'b0);
        for (int i = 0; i < 256; i++) mvalid[i] = 1'b0;
        m_hits = 0; m_misses = 0;
        @(posedge clk); #1; idle_chk = 1'b1;
        do_req(1'b0, 16'h0010, 32'h0, 0, 0);
        chk("lit_post_rst_latency", last_resp_cyc, 3);
        chk("lit_post_rst_mem", mem_cycles, 1);
        do_req(1'b0, 16'hFFFF, 32'h0, 0, 0);
        do_req(1'b0, 16'h0010, 32'h0, 0, 0);

        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
